hazard_unit_mc: RTL

Parametrised pipeline hazard controller for the RISC-V core datapath, sitting between the ID/EX, EX/MEM and MEM/WB pipeline registers and the global stall/flush network. It supports an arbitrary number of register read ports, produces per-port 2-bit forwarding selects from the MEM and WB stages, and detects load-use hazards. It also runs a multi-cycle data-memory wait FSM with a configurable latency, merges the GEMM wait, and holds any flush request that arrives during a stall until that stall releases.

---
 rtl/hazard_unit_mc.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: pipeline hazard controller.
// Generates per-port forwarding selects from the MEM and WB stages and detects
// load-use hazards. It also runs the data-memory wait FSM, merges the GEMM wait
// into the global stall, and holds any flush that arrives during a stall.
// Optional feature macro: HAZ_MEM_READY_EN. When it is defined, the memory wait
// is ended by a dmem_ready handshake and the fixed-latency counter is removed.
module hazard_unit_mc #(
  parameter int unsigned NUM_RD_PORTS = 2,
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned MEM_LAT      = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_RD_PORTS*REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0]              rd_mem,
  input  logic [REG_AW-1:0]              rd_wb,
  input  logic                           reg_wr_mem,
  input  logic                           reg_wr_wb,
  input  logic [1:0]                     wb_sel_mem,
  input  logic                           mem_read,
  input  logic                           pc_sel,
  input  logic                           epc_taken,
  input  logic                           wait_for_gemm,
`ifdef HAZ_MEM_READY_EN
  input  logic                           dmem_ready,
`endif
  output logic [NUM_RD_PORTS*2-1:0]      fwd_sel,
  output logic                           stall,
  output logic                           flush,
  output logic                           load_use,
  output logic                           mem_busy
);

  localparam int unsigned FWD_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  mem_state_t state_q;
  mem_state_t state_d;
  logic       mem_stall;
  logic       mem_valid;
  logic       wb_valid;
  logic       mem_is_alu;
  logic       flush_req;
  logic       flush_hold_q;

  logic [NUM_RD_PORTS-1:0] mem_hit;
  logic [NUM_RD_PORTS-1:0] wb_hit;

  // A stage is a producer only when it writes a non-x0 register
  assign mem_valid  = reg_wr_mem && (rd_mem != '0);
  assign wb_valid   = reg_wr_wb && (rd_wb != '0);
  assign mem_is_alu = (wb_sel_mem == 2'b01);

  // Per-port address comparison against both producers
  for (genvar g = 0; g < NUM_RD_PORTS; g++) begin : g_port
    logic [REG_AW-1:0] rs;
    assign rs         = rs_addr[g*REG_AW +: REG_AW];
    assign mem_hit[g] = mem_valid && (rs == rd_mem);
    assign wb_hit[g]  = wb_valid && (rs == rd_wb);
  end

  // Forwarding select (MEM ALU result beats WB) and load-use detection
  always_comb begin
    fwd_sel  = '0;
    load_use = 1'b0;
    for (int i = 0; i < int'(NUM_RD_PORTS); i++) begin
      if (mem_hit[i] && mem_is_alu) begin
        fwd_sel[i*FWD_W +: FWD_W] = 2'b01;
      end else if (wb_hit[i]) begin
        fwd_sel[i*FWD_W +: FWD_W] = 2'b10;
      end
      if (mem_hit[i] && !mem_is_alu) begin
        load_use = 1'b1;
      end
    end
  end

`ifdef HAZ_MEM_READY_EN

  // Memory FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory FSM next state: BUSY ends on the cycle dmem_ready is seen
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mem_read) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (dmem_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory FSM outputs: stall until the memory reports ready
  always_comb begin
    mem_stall = 1'b0;
    mem_busy  = 1'b0;
    case (state_q)
      IDLE: mem_stall = mem_read;
      BUSY: begin
        mem_busy  = 1'b1;
        mem_stall = !dmem_ready;
      end
      default: begin
        mem_stall = 1'b0;
        mem_busy  = 1'b0;
      end
    endcase
  end

`else

  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Memory FSM state and latency counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory FSM next state: count down the remaining latency, then release
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_read) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(MEM_LAT - 1);
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Memory FSM outputs: the load cycle plus MEM_LAT-1 busy cycles stall
  always_comb begin
    mem_stall = 1'b0;
    mem_busy  = 1'b0;
    case (state_q)
      IDLE: mem_stall = mem_read;
      BUSY: begin
        mem_busy  = 1'b1;
        mem_stall = (cnt_q != '0);
      end
      default: begin
        mem_stall = 1'b0;
        mem_busy  = 1'b0;
      end
    endcase
  end

`endif

  assign stall     = mem_stall | load_use | wait_for_gemm;
  assign flush_req = pc_sel | epc_taken;

  // Remember a redirect seen while stalled; drop it once the stall releases
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_hold_q <= 1'b0;
    end else if (stall) begin
      flush_hold_q <= flush_hold_q | flush_req;
    end else begin
      flush_hold_q <= 1'b0;
    end
  end

  assign flush = (flush_req | flush_hold_q) & ~stall;

endmodule
